// File: rtl/store_align_buffer.sv
// Store aligner and DEPTH-entry in-order queue toward data memory; flags misaligned stores and load hazards.
// Latency: push at edge N shows at the head after edge N (no bypass); backpressure: in_ready low when full.
module store_align_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [2:0]               in_sel,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [DATA_W-1:0]        out_data,
   output logic [DATA_W/8-1:0]      out_strb,
   output logic                     align_err,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [ADDR_W-1:0]        chk_addr,
   output logic                     chk_hit
);

   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = $clog2(LANES);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] SEL_SB  = 3'd0;
   localparam logic [2:0] SEL_SH  = 3'd1;
   localparam logic [2:0] SEL_SW  = 3'd2;
   localparam logic [2:0] SEL_SWL = 3'd3;
   localparam logic [2:0] SEL_SWR = 3'd4;
   localparam logic [2:0] SEL_SD  = 3'd5;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [LANES-1:0]  strb;
   } entry_t;

   entry_t            mem [DEPTH];
   entry_t            new_entry;
   entry_t            head;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   logic [DATA_W-1:0] wext;
   logic [1:0]        a;
   logic [1:0]        sr;
   logic [2:0]        wo;
   logic [5:0]        bsh;
   logic [5:0]        wsh;
   logic [3:0]        ws4;
   logic [DATA_W-1:0] al_data;
   logic [LANES-1:0]  al_strb;
   logic              legal;
   logic              accept;
   logic              push;
   logic              pop;
   logic              unused_chk;

   // All data shifts run at full bus width, so bytes past the written lanes may carry
   // shifted-out word bytes; only the strobes define what memory actually writes.
   always_comb begin
      wext    = DATA_W'(in_data[31:0]);
      a       = in_addr[1:0];
      sr      = 2'd3 - a;
      wo      = (DATA_W == 64) ? {in_addr[2], 2'b00} : 3'd0;
      bsh     = {wo + {1'b0, a}, 3'b000};
      wsh     = {wo, 3'b000};
      ws4     = 4'h0;
      al_data = '0;
      al_strb = '0;
      legal   = 1'b0;
      case (in_sel)
         SEL_SB: begin
            legal   = 1'b1;
            al_data = wext << bsh;
            ws4     = 4'b0001 << a;
            al_strb = LANES'(ws4) << wo;
         end
         SEL_SH: begin
            legal   = ~a[0];
            al_data = wext << bsh;
            ws4     = 4'b0011 << a;
            al_strb = LANES'(ws4) << wo;
         end
         SEL_SW: begin
            legal   = (a == 2'd0);
            al_data = wext << wsh;
            ws4     = 4'hF;
            al_strb = LANES'(ws4) << wo;
         end
         SEL_SWL: begin
            legal   = 1'b1;
            al_data = (wext >> {a, 3'b000}) << wsh;
            ws4     = 4'hF >> a;
            al_strb = LANES'(ws4) << wo;
         end
         SEL_SWR: begin
            legal   = 1'b1;
            al_data = (wext << {sr, 3'b000}) << wsh;
            ws4     = 4'hF << sr;
            al_strb = LANES'(ws4) << wo;
         end
         SEL_SD: begin
            legal   = (DATA_W == 64) && (in_addr[2:0] == 3'd0);
            al_data = in_data;
            al_strb = '1;
         end
         default: legal = 1'b0;
      endcase
   end

   assign new_entry.addr = {in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
   assign new_entry.data = al_data;
   assign new_entry.strb = al_strb;

   assign in_ready  = resetn && (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign accept    = in_valid & in_ready;
   assign push      = accept & legal;
   assign pop       = out_valid & out_ready;

   assign head     = mem[rd_ptr];
   assign out_addr = head.addr;
   assign out_data = head.data;
   assign out_strb = head.strb;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         align_err <= 1'b0;
      end else begin
         align_err <= accept & ~legal;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= new_entry;
   end

   // An entry is live when its distance from the head is below count; the slot being
   // written this cycle is not yet live, the popping head still is.
   always_comb begin
      chk_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, PTR_W'(i) - rd_ptr} < count) &&
             (mem[i].addr[ADDR_W-1:OFF_W] == chk_addr[ADDR_W-1:OFF_W]))
            chk_hit = 1'b1;
      end
   end

   assign unused_chk = ^chk_addr[OFF_W-1:0];

endmodule
